// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the NeoPixel chain controller.
package neopixel_pkg;

   // Controller FSM states; also exported on the debug state output.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } state_t;

   // Byte offset of each colour channel inside a pixel's 3-byte slot.
   localparam int CH_R = 0;
   localparam int CH_G = 1;
   localparam int CH_B = 2;

   localparam int BITS_PER_PIXEL = 24;

   // WS2812 expects green first, then red, then blue, each MSB first.
   function automatic logic [23:0] pack_grb(input logic [7:0] r,
                                            input logic [7:0] g,
                                            input logic [7:0] b);
      return {g, r, b};
   endfunction

endpackage

// File: rtl/neopixel_chain_ctrl_if.sv
// Load-stream / trigger / serial-output bundle of the NeoPixel chain controller.
//
// Handshake: there is no back-pressure. in_valid, in_sof and update are
// single-cycle strobes sampled on every rising CLK edge and always accepted;
// in_byte is only meaningful while in_valid is high. dout, busy, frame_done,
// load_ptr and state are registered outputs of the controller.
interface neopixel_chain_ctrl_if #(
   parameter int N_PIXELS = 10
);
   import neopixel_pkg::*;

   localparam int PTR_W = $clog2(3 * N_PIXELS);

   logic [7:0]       in_byte;
   logic             in_valid;
   logic             in_sof;
   logic             update;
   logic             dout;
   logic             busy;
   logic             frame_done;
   logic [PTR_W-1:0] load_ptr;
   state_t           state;

   // Byte source / trigger side (board top or testbench).
   modport master (
      output in_byte, in_valid, in_sof, update,
      input  dout, busy, frame_done, load_ptr, state
   );

   // Controller side.
   modport slave (
      input  in_byte, in_valid, in_sof, update,
      output dout, busy, frame_done, load_ptr, state
   );

endinterface

// File: rtl/ws2812_bit_tx.sv
// One WS2812 data bit: T_BIT clocks long, high for T0H (0) or T1H (1) clocks.
// A new bit may be started in the last cycle of the current one, so back-to-back
// bits have no gap.
module ws2812_bit_tx #(
   parameter int T_BIT = 15,
   parameter int T0H   = 5,
   parameter int T1H   = 10
) (
   input  logic CLK,
   input  logic RST,
   input  logic bit_valid,
   input  logic bit_value,
   output logic bit_done,
   output logic dout
);

   localparam int PH_W = $clog2(T_BIT);

   logic            active;
   logic [PH_W-1:0] phase;
   logic [PH_W-1:0] high_len;

   // Last cycle of the bit currently on the wire.
   always_comb bit_done = active && (phase == PH_W'(T_BIT - 1));

   // Bit-phase counter and registered data line.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         active   <= 1'b0;
         phase    <= '0;
         high_len <= '0;
         dout     <= 1'b0;
      end else if (bit_valid && (!active || bit_done)) begin
         active   <= 1'b1;
         phase    <= '0;
         high_len <= bit_value ? PH_W'(T1H) : PH_W'(T0H);
         dout     <= 1'b1;
      end else if (active) begin
         if (bit_done) begin
            active <= 1'b0;
            phase  <= '0;
            dout   <= 1'b0;
         end else begin
            phase <= phase + PH_W'(1);
            dout  <= ((phase + PH_W'(1)) < high_len);
         end
      end
   end

endmodule

// File: rtl/neopixel_chain_ctrl.sv
// WS2812 chain controller: byte-stream frame buffer loader, periodic / on-demand
// refresh, and per-pixel sequencing onto the serial line via ws2812_bit_tx.
module neopixel_chain_ctrl #(
   parameter int N_PIXELS       = 10,
   parameter int T_BIT          = 15,
   parameter int T0H            = 5,
   parameter int T1H            = 10,
   parameter int T_RESET        = 960,
   parameter int REFRESH_CYCLES = 2097152
) (
   input logic                 CLK,
   input logic                 RST,
   neopixel_chain_ctrl_if.slave bus
);
   import neopixel_pkg::*;

   localparam int NBYTES = 3 * N_PIXELS;
   localparam int PTR_W  = $clog2(NBYTES);
   localparam int PIX_W  = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
   localparam int LAT_W  = (T_RESET > 1) ? $clog2(T_RESET) : 1;
   localparam int RC_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   if (!(T0H >= 1 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
      $error("neopixel_chain_ctrl: bit timing must satisfy 1 <= T0H < T1H < T_BIT");
   end
   if (N_PIXELS < 1 || N_PIXELS > 255) begin : g_bad_pixels
      $error("neopixel_chain_ctrl: N_PIXELS must be 1..255");
   end
   if (T_RESET < 1) begin : g_bad_reset_gap
      $error("neopixel_chain_ctrl: T_RESET must be at least 1");
   end

   // Frame buffer: byte p is pixel p/3, channel p%3. Not reset; contents persist
   // across RST so a frame after reset still shows the last loaded image.
   logic [7:0]       fb [NBYTES];
   logic [PTR_W-1:0] load_ptr_q;
   logic [PTR_W-1:0] wr_idx;
   logic [PTR_W-1:0] wr_next;

   // in_sof together with in_valid writes the byte at index 0.
   always_comb begin
      wr_idx  = bus.in_sof ? '0 : load_ptr_q;
      wr_next = (wr_idx == PTR_W'(NBYTES - 1)) ? '0 : wr_idx + PTR_W'(1);
   end

   // Load pointer: advances on each byte, wraps at the end of the frame.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         load_ptr_q <= '0;
      end else if (bus.in_valid) begin
         load_ptr_q <= wr_next;
      end else if (bus.in_sof) begin
         load_ptr_q <= '0;
      end
   end

   // Frame buffer write port; accepted in every state (no double buffering).
   always_ff @(posedge CLK) begin
      if (bus.in_valid) begin
         fb[wr_idx] <= bus.in_byte;
      end
   end

   // Refresh timer and trigger.
   logic [RC_W-1:0] ref_cnt;
   logic            refresh_tc;
   logic            trigger;

   always_comb begin
      refresh_tc = (REFRESH_CYCLES != 0) && (ref_cnt == RC_W'(REFRESH_CYCLES - 1));
      trigger    = bus.update || refresh_tc;
   end

   // Free-running refresh counter; held at zero when auto refresh is disabled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ref_cnt <= '0;
      end else if (REFRESH_CYCLES != 0) begin
         ref_cnt <= refresh_tc ? '0 : ref_cnt + RC_W'(1);
      end
   end

   // Sequencer state.
   state_t           state;
   logic             pending;
   logic [PIX_W-1:0] pix;
   logic [4:0]       bit_idx;
   logic [23:0]      shift_q;
   logic [LAT_W-1:0] lat_cnt;
   logic             busy_q;
   logic             frame_done_q;
   logic [PTR_W-1:0] pix_base;
   logic [23:0]      pix_word;
   logic             bit_valid;
   logic             bit_value;
   logic             bit_done;
   logic             tx_dout;

   // Current pixel word, read straight from the buffer during LOAD.
   always_comb begin
      pix_base = PTR_W'(3 * pix);
      pix_word = pack_grb(fb[pix_base + PTR_W'(CH_R)],
                          fb[pix_base + PTR_W'(CH_G)],
                          fb[pix_base + PTR_W'(CH_B)]);
   end

   // Bit requests: first bit straight from LOAD, the rest chained on bit_done.
   always_comb begin
      bit_valid = (state == LOAD) ||
                  ((state == SHIFT) && bit_done && (bit_idx != 5'(BITS_PER_PIXEL - 1)));
      bit_value = (state == LOAD) ? pix_word[23] : shift_q[22];
   end

   // Main FSM: IDLE -> LOAD -> SHIFT (x24) -> LOAD ... -> LATCH -> IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         pending      <= 1'b0;
         pix          <= '0;
         bit_idx      <= '0;
         shift_q      <= '0;
         lat_cnt      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (trigger) begin
            pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (pending || trigger) begin
                  state   <= LOAD;
                  busy_q  <= 1'b1;
                  pending <= 1'b0;
                  pix     <= '0;
               end
            end
            LOAD: begin
               shift_q <= pix_word;
               bit_idx <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               if (bit_done) begin
                  if (bit_idx == 5'(BITS_PER_PIXEL - 1)) begin
                     if (pix == PIX_W'(N_PIXELS - 1)) begin
                        state   <= LATCH;
                        lat_cnt <= '0;
                     end else begin
                        pix   <= pix + PIX_W'(1);
                        state <= LOAD;
                     end
                  end else begin
                     shift_q <= {shift_q[22:0], 1'b0};
                     bit_idx <= bit_idx + 5'd1;
                  end
               end
            end
            LATCH: begin
               if (lat_cnt == LAT_W'(T_RESET - 1)) begin
                  state        <= IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
                  pix          <= '0;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   ws2812_bit_tx #(
      .T_BIT (T_BIT),
      .T0H   (T0H),
      .T1H   (T1H)
   ) u_bit_tx (
      .CLK       (CLK),
      .RST       (RST),
      .bit_valid (bit_valid),
      .bit_value (bit_value),
      .bit_done  (bit_done),
      .dout      (tx_dout)
   );

   assign bus.dout       = tx_dout;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.load_ptr   = load_ptr_q;
   assign bus.state      = state;

endmodule
